// File: rtl/servo_frame_scheduler.sv
// Frame-rate servo command scheduler: conditions joystick samples, slews the committed
// X/Y commands toward the targets once per frame, and ramps to centre when samples stop.
module servo_frame_scheduler #(
  parameter int FRAME_CYCLES   = 2_000_000,
  parameter int MIN_US         = 1000,
  parameter int MAX_US         = 2000,
  parameter int CENTER_US      = 1500,
  parameter int DEADBAND       = 20,
  parameter int MAX_STEP       = 50,
  parameter int TIMEOUT_FRAMES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [10:0] x_in,
  input  logic [10:0] y_in,
  output logic [10:0] x_cmd,
  output logic [10:0] y_cmd,
  output logic        commit,
  output logic        failsafe
);

  localparam int                CNT_W     = $clog2(FRAME_CYCLES);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [10:0]       MIN_V     = 11'(MIN_US);
  localparam logic [10:0]       MAX_V     = 11'(MAX_US);
  localparam logic [10:0]       CENTER_V  = 11'(CENTER_US);
  localparam logic [10:0]       DB_LO     = 11'(CENTER_US - DEADBAND);
  localparam logic [10:0]       DB_HI     = 11'(CENTER_US + DEADBAND);
  localparam logic [10:0]       STEP_V    = 11'(MAX_STEP);
  localparam logic signed [11:0] STEP_S   = 12'(MAX_STEP);
  localparam logic [7:0]        TIMEOUT_V = 8'(TIMEOUT_FRAMES);

  typedef enum logic {ST_FAILSAFE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] frame_cnt, frame_cnt_nxt;
  logic [7:0]       missed, missed_nxt, missed_upd;
  logic             seen, seen_nxt, seen_now;
  logic             terminal, timeout, commit_nxt;
  logic [10:0]      x_tgt, y_tgt, x_tgt_nxt, y_tgt_nxt;
  logic [10:0]      x_cmd_nxt, y_cmd_nxt, x_step_tgt, y_step_tgt;

  function automatic logic [10:0] condition(input logic [10:0] v);
    logic [10:0] c;
    if (v < MIN_V)      c = MIN_V;
    else if (v > MAX_V) c = MAX_V;
    else                c = v;
    if (c >= DB_LO && c <= DB_HI) c = CENTER_V;
    return c;
  endfunction

  function automatic logic [10:0] slew(input logic [10:0] cmd, input logic [10:0] tgt);
    logic signed [11:0] diff;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cmd});
    if (diff > STEP_S)       return cmd + STEP_V;
    else if (diff < -STEP_S) return cmd - STEP_V;
    else                     return tgt;
  endfunction

  always_comb begin
    terminal   = (frame_cnt == LAST_CNT);
    seen_now   = seen | sample_valid;
    missed_upd = seen_now ? 8'd0 : ((missed == 8'hFF) ? missed : missed + 8'd1);
    timeout    = terminal && (state == ST_RUN) && (missed_upd >= TIMEOUT_V);
    // The frame that trips the timeout already steps toward centre.
    x_step_tgt = timeout ? CENTER_V : x_tgt;
    y_step_tgt = timeout ? CENTER_V : y_tgt;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt + CNT_W'(1);
    seen_nxt      = seen_now;
    missed_nxt    = missed;
    commit_nxt    = 1'b0;
    x_cmd_nxt     = x_cmd;
    y_cmd_nxt     = y_cmd;
    x_tgt_nxt     = x_tgt;
    y_tgt_nxt     = y_tgt;

    if (terminal) begin
      frame_cnt_nxt = '0;
      seen_nxt      = 1'b0;
      missed_nxt    = missed_upd;
      commit_nxt    = 1'b1;
      x_cmd_nxt     = slew(x_cmd, x_step_tgt);
      y_cmd_nxt     = slew(y_cmd, y_step_tgt);
    end

    // A sample and a timeout are mutually exclusive: the sample marks the frame as seen.
    if (sample_valid) begin
      x_tgt_nxt = condition(x_in);
      y_tgt_nxt = condition(y_in);
      state_nxt = ST_RUN;
    end else if (timeout) begin
      x_tgt_nxt = CENTER_V;
      y_tgt_nxt = CENTER_V;
      state_nxt = ST_FAILSAFE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous and wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FAILSAFE;
      frame_cnt <= '0;
      seen      <= 1'b0;
      missed    <= 8'd0;
      commit    <= 1'b0;
      x_cmd     <= CENTER_V;
      y_cmd     <= CENTER_V;
      x_tgt     <= CENTER_V;
      y_tgt     <= CENTER_V;
    end else begin
      state     <= state_nxt;
      frame_cnt <= frame_cnt_nxt;
      seen      <= seen_nxt;
      missed    <= missed_nxt;
      commit    <= commit_nxt;
      x_cmd     <= x_cmd_nxt;
      y_cmd     <= y_cmd_nxt;
      x_tgt     <= x_tgt_nxt;
      y_tgt     <= y_tgt_nxt;
    end
  end

  assign failsafe = (state == ST_FAILSAFE);

endmodule

// File: tb/tb_servo_frame_scheduler.sv
// Self-checking bench for servo_frame_scheduler: directed scenarios plus random traffic,
// all compared against an integer behavioural model of the frame/slew/timeout rules.
module tb_servo_frame_scheduler;

  localparam int FRAME  = 20;
  localparam int TMO    = 3;
  localparam int CENTER = 1500;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [10:0] x_in = '0;
  logic [10:0] y_in = '0;
  logic [10:0] x_cmd, y_cmd;
  logic        commit, failsafe;
  logic [23:0] dut_out;

  servo_frame_scheduler #(.FRAME_CYCLES(FRAME), .TIMEOUT_FRAMES(TMO)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .x_in(x_in), .y_in(y_in),
    .x_cmd(x_cmd), .y_cmd(y_cmd), .commit(commit), .failsafe(failsafe)
  );

  assign dut_out = {x_cmd, y_cmd, commit, failsafe};

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_commit = 0;
  int commit_gap = 0;

  // Behavioural model state
  int m_cnt, m_missed, m_x, m_y, m_tx, m_ty;
  bit m_seen, m_run, m_commit;

  // Per-window observations
  int          win_bad, win_commits, win_gap;
  logic [10:0] win_x, win_y;
  logic        win_fs, win_fs_post;

  function automatic int cond(int v);
    int c;
    c = (v < 1000) ? 1000 : ((v > 2000) ? 2000 : v);
    if (c - CENTER <= 20 && CENTER - c <= 20) c = CENTER;
    return c;
  endfunction

  function automatic int slew(int cmd, int tgt);
    if (tgt - cmd > 50) return cmd + 50;
    if (cmd - tgt > 50) return cmd - 50;
    return tgt;
  endfunction

  function automatic logic [23:0] model_out();
    return {11'(m_x), 11'(m_y), m_commit, ~m_run};
  endfunction

  task automatic model_edge();
    bit term, seen_now, fs_enter;
    if (rst) begin
      m_cnt = 0; m_seen = 0; m_missed = 0; m_run = 0; m_commit = 0;
      m_tx = CENTER; m_ty = CENTER; m_x = CENTER; m_y = CENTER;
      return;
    end
    term     = (m_cnt == FRAME - 1);
    seen_now = m_seen || sample_valid;
    m_commit = term;
    if (term) begin
      m_missed = seen_now ? 0 : ((m_missed < 255) ? m_missed + 1 : 255);
      fs_enter = m_run && (m_missed >= TMO);
      if (fs_enter) begin
        m_tx = CENTER; m_ty = CENTER; m_run = 0;
      end
      m_x = slew(m_x, m_tx);
      m_y = slew(m_y, m_ty);
      m_seen = 0;
      m_cnt  = 0;
    end else begin
      m_cnt++;
      m_seen = seen_now;
    end
    if (sample_valid) begin
      m_tx = cond(int'(x_in)); m_ty = cond(int'(y_in)); m_run = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    if (commit === 1'b1) begin
      commit_gap  = cyc - last_commit;
      last_commit = cyc;
    end
  endtask

  // One frame-long window starting at frame_cnt == 1, with at most one sample before the terminal cycle.
  task automatic drive_window(input bit send, input int sx, input int sy);
    int off;
    off = int'($urandom_range(17, 0));
    win_bad = 0; win_commits = 0; win_fs_post = failsafe;
    for (int t = 0; t < FRAME; t++) begin
      sample_valid = send && (t == off);
      x_in = (t == off) ? 11'(sx) : 11'($urandom);
      y_in = (t == off) ? 11'(sy) : 11'($urandom);
      tick();
      if (dut_out !== model_out()) win_bad++;
      if (send && t == off) win_fs_post = failsafe;
      if (commit === 1'b1) begin
        win_commits++; win_x = x_cmd; win_y = y_cmd; win_fs = failsafe; win_gap = commit_gap;
      end
    end
    sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    bit exp_c;
    rst = 1'b1; sample_valid = 1'b0;
    repeat (3) tick();
    vectors++;
    if (dut_out !== {11'd1500, 11'd1500, 1'b0, 1'b1}) begin
      miscompares++; $display("FAIL reset_state: got %h required %h", dut_out, {11'd1500, 11'd1500, 1'b0, 1'b1});
    end
    rst = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      exp_c = (i == FRAME - 1);
      vectors++;
      if (commit !== exp_c || x_cmd !== 11'd1500 || y_cmd !== 11'd1500 || failsafe !== 1'b1 ||
          dut_out !== model_out()) begin
        miscompares++;
        $display("FAIL reset_first_commit cycle %0d: got commit=%b x=%0d y=%0d fs=%b required commit=%b x=1500 y=1500 fs=1",
                 i + 1, commit, x_cmd, y_cmd, failsafe, exp_c);
      end
    end
  endtask

  task automatic test_slew();
    sample_valid = 1'b1; x_in = 11'd2000; y_in = 11'd1000;
    tick();
    sample_valid = 1'b0;
    vectors++;
    if (failsafe !== 1'b0 || dut_out !== model_out()) begin
      miscompares++; $display("FAIL slew_exit_failsafe: got fs=%b required 0", failsafe);
    end
    for (int k = 1; k <= 10; k++) begin
      drive_window(1'b1, 2000, 1000);
      vectors++;
      if (win_bad != 0 || win_commits != 1 || win_gap != FRAME || win_fs !== 1'b0 ||
          win_x !== 11'(1500 + 50 * k) || win_y !== 11'(1500 - 50 * k)) begin
        miscompares++;
        $display("FAIL slew frame %0d: got x=%0d y=%0d gap=%0d commits=%0d model_diffs=%0d required x=%0d y=%0d gap=%0d",
                 k, win_x, win_y, win_gap, win_commits, win_bad, 1500 + 50 * k, 1500 - 50 * k, FRAME);
      end
    end
  endtask

  task automatic test_timeout();
    int ex, ey;
    bit efs;
    for (int j = 1; j <= 12; j++) begin
      drive_window(1'b0, 0, 0);
      ex  = (j < TMO) ? 2000 : ((2000 - 50 * (j - 2) > 1500) ? 2000 - 50 * (j - 2) : 1500);
      ey  = (j < TMO) ? 1000 : ((1000 + 50 * (j - 2) < 1500) ? 1000 + 50 * (j - 2) : 1500);
      efs = (j >= TMO);
      vectors++;
      if (win_bad != 0 || win_commits != 1 || win_fs !== efs || win_x !== 11'(ex) || win_y !== 11'(ey)) begin
        miscompares++;
        $display("FAIL timeout frame %0d: got x=%0d y=%0d fs=%b model_diffs=%0d required x=%0d y=%0d fs=%b",
                 j, win_x, win_y, win_fs, win_bad, ex, ey, efs);
      end
    end
    for (int j = 1; j <= 7; j++) begin
      drive_window(1'b1, 1800, 1500);
      ex = (1500 + 50 * j < 1800) ? 1500 + 50 * j : 1800;
      vectors++;
      if (win_bad != 0 || win_commits != 1 || win_fs !== 1'b0 || win_fs_post !== 1'b0 ||
          win_x !== 11'(ex) || win_y !== 11'd1500) begin
        miscompares++;
        $display("FAIL recover frame %0d: got x=%0d y=%0d fs=%b fs_after_sample=%b model_diffs=%0d required x=%0d y=1500 fs=0",
                 j, win_x, win_y, win_fs, win_fs_post, win_bad, ex);
      end
    end
  endtask

  task automatic test_boundary();
    int ex, bad;
    for (int j = 1; j <= 6; j++) begin
      drive_window(1'b1, 1500, 1500);
      ex = (1800 - 50 * j > 1500) ? 1800 - 50 * j : 1500;
      vectors++;
      if (win_bad != 0 || win_commits != 1 || win_x !== 11'(ex)) begin
        miscompares++;
        $display("FAIL boundary_settle frame %0d: got x=%0d model_diffs=%0d required x=%0d", j, win_x, win_bad, ex);
      end
    end
    // One empty frame, then idle up to the next terminal cycle.
    bad = 0;
    for (int i = 0; i < 2 * FRAME - 2; i++) begin
      tick();
      if (dut_out !== model_out()) bad++;
    end
    vectors++;
    if (bad != 0 || dut.missed !== 8'd1) begin
      miscompares++; $display("FAIL boundary_missed_before: got missed=%0d model_diffs=%0d required missed=1", dut.missed, bad);
    end
    sample_valid = 1'b1; x_in = 11'd1700; y_in = 11'd1500;
    tick();
    sample_valid = 1'b0;
    vectors++;
    if (commit !== 1'b1 || x_cmd !== 11'd1500 || dut.missed !== 8'd0 || dut_out !== model_out()) begin
      miscompares++;
      $display("FAIL boundary_terminal_sample: got commit=%b x=%0d missed=%0d required commit=1 x=1500 missed=0",
               commit, x_cmd, dut.missed);
    end
    bad = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (dut_out !== model_out()) bad++;
    end
    vectors++;
    if (bad != 0 || commit !== 1'b1 || x_cmd !== 11'd1550) begin
      miscompares++;
      $display("FAIL boundary_next_commit: got commit=%b x=%0d model_diffs=%0d required commit=1 x=1550", commit, x_cmd, bad);
    end
  endtask

  task automatic test_reset_mid_ramp();
    int n;
    bit got;
    tick();
    for (int j = 1; j <= 4; j++) begin
      drive_window(1'b1, 2000, 1500);
      vectors++;
      if (win_bad != 0 || win_commits != 1 || win_x !== 11'(1550 + 50 * j)) begin
        miscompares++;
        $display("FAIL midramp_ramp frame %0d: got x=%0d model_diffs=%0d required x=%0d", j, win_x, win_bad, 1550 + 50 * j);
      end
    end
    repeat (9) tick();
    rst = 1'b1;
    tick();
    vectors++;
    if (dut_out !== {11'd1500, 11'd1500, 1'b0, 1'b1} || dut_out !== model_out()) begin
      miscompares++; $display("FAIL midramp_reset: got %h required %h", dut_out, {11'd1500, 11'd1500, 1'b0, 1'b1});
    end
    rst = 1'b0;
    n = 0; got = 0;
    for (int i = 0; i < 2 * FRAME && !got; i++) begin
      tick();
      n++;
      got = (commit === 1'b1);
    end
    vectors++;
    if (!got || n != FRAME || x_cmd !== 11'd1500) begin
      miscompares++;
      $display("FAIL midramp_first_commit: got commit_seen=%b after %0d cycles x=%0d required after %0d cycles x=1500",
               got, n, x_cmd, FRAME);
    end
  endtask

  task automatic test_conditioning();
    int ex;
    tick();
    drive_window(1'b1, 1515, int'($urandom_range(2047, 0)));
    vectors++;
    if (win_bad != 0 || win_commits != 1 || win_x !== 11'd1500) begin
      miscompares++; $display("FAIL cond_deadband: got x=%0d model_diffs=%0d required x=1500", win_x, win_bad);
    end
    drive_window(1'b1, 1521, int'($urandom_range(2047, 0)));
    vectors++;
    if (win_bad != 0 || win_commits != 1 || win_x !== 11'd1521) begin
      miscompares++; $display("FAIL cond_outside_deadband: got x=%0d model_diffs=%0d required x=1521", win_x, win_bad);
    end
    for (int j = 1; j <= 10; j++) begin
      drive_window(1'b1, 2047, int'($urandom_range(2047, 0)));
      ex = (1521 + 50 * j < 2000) ? 1521 + 50 * j : 2000;
      vectors++;
      if (win_bad != 0 || win_commits != 1 || win_x !== 11'(ex)) begin
        miscompares++; $display("FAIL cond_clamp_high frame %0d: got x=%0d model_diffs=%0d required x=%0d", j, win_x, win_bad, ex);
      end
    end
    for (int j = 1; j <= 20; j++) begin
      drive_window(1'b1, 0, int'($urandom_range(2047, 0)));
      ex = (2000 - 50 * j > 1000) ? 2000 - 50 * j : 1000;
      vectors++;
      if (win_bad != 0 || win_commits != 1 || win_x !== 11'(ex)) begin
        miscompares++; $display("FAIL cond_clamp_low frame %0d: got x=%0d model_diffs=%0d required x=%0d", j, win_x, win_bad, ex);
      end
    end
  endtask

  task automatic test_random();
    bit quiet;
    quiet = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      if (i % 80 == 0) quiet = ($urandom_range(1, 0) == 1);
      rst          = ($urandom_range(399, 0) == 0);
      sample_valid = !quiet && ($urandom_range(5, 0) == 0);
      x_in         = 11'($urandom);
      y_in         = ($urandom_range(3, 0) == 0) ? 11'(1480 + $urandom_range(40, 0)) : 11'($urandom);
      tick();
      vectors++;
      if (dut_out !== model_out()) begin
        miscompares++;
        if (miscompares < 20)
          $display("FAIL random cycle %0d: got %h required %h", cyc, dut_out, model_out());
      end
    end
    rst = 1'b0; sample_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_slew();
    test_timeout();
    test_boundary();
    test_reset_mid_ramp();
    test_conditioning();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
